// File: rtl/sdram_pkg.sv
// Shared SDRAM constants: address field layout, default burst length and
// the write-buffer FSM encoding used by the controller and both buffers.
package sdram_pkg;

  localparam int BANK_W       = 2;
  localparam int ROW_W        = 13;
  localparam int COL_W        = 9;
  localparam int SDRAM_ADDR_W = BANK_W + ROW_W + COL_W;

  localparam int DEF_BURST_LEN = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  typedef enum logic [1:0] {
    WR_IDLE  = ST_IDLE,
    WR_REQ   = ST_REQ,
    WR_BURST = ST_BURST
  } wr_state_t;

endpackage

// File: rtl/sdram_wr_buffer_if.sv
// Pixel-in / burst-write-out bundle of the SDRAM write buffer.
// frame_bank exists only when FRAME_PINGPONG_EN is defined.
interface sdram_wr_buffer_if
  import sdram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 9,
  parameter int ADDR_W  = SDRAM_ADDR_W
);

  logic              frame_start;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              wr_data_en;
  logic [DATA_W-1:0] wr_data;
  logic [FIFO_AW:0]  fifo_level;
  logic              overflow;
`ifdef FRAME_PINGPONG_EN
  logic              frame_bank;

  modport master (
    input  frame_start, pix_valid, pix_data, wr_ack, wr_data_en,
    output wr_req, wr_addr, wr_data, fifo_level, overflow, frame_bank
  );
  modport slave (
    output frame_start, pix_valid, pix_data, wr_ack, wr_data_en,
    input  wr_req, wr_addr, wr_data, fifo_level, overflow, frame_bank
  );
`else
  modport master (
    input  frame_start, pix_valid, pix_data, wr_ack, wr_data_en,
    output wr_req, wr_addr, wr_data, fifo_level, overflow
  );
  modport slave (
    output frame_start, pix_valid, pix_data, wr_ack, wr_data_en,
    input  wr_req, wr_addr, wr_data, fifo_level, overflow
  );
`endif

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO on a registered-read RAM, with
// flush, occupancy and full/empty flags.
module sync_fifo_fwft #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 9
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [FIFO_AW:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  byp_data_reg;
  logic               byp_sel_reg;
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW-1:0] wr_ptr_next, rd_ptr_next, wr_addr;
  logic [FIFO_AW:0]   count_reg, count_next;
  logic               do_push, do_pop;

  assign full    = (count_reg == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  // A flush empties the FIFO first, so a same-cycle push always lands
  assign do_push = push && (flush || !full);
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_addr     = flush ? '0 : wr_ptr_reg;
    rd_ptr_next = flush ? '0 : rd_ptr_reg + FIFO_AW'(do_pop);
    wr_ptr_next = wr_addr + FIFO_AW'(do_push);
    count_next  = flush ? (FIFO_AW+1)'(do_push)
                        : count_reg + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
  end

  // RAM reads the next head address every cycle so the head is ready early
  always_ff @(posedge sclk) begin
    if (do_push)
      mem[wr_addr] <= din;
    ram_q <= mem[rd_ptr_next];
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      byp_sel_reg  <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      // word written into the slot that becomes head: RAM read would be stale
      byp_sel_reg  <= do_push && (wr_addr == rd_ptr_next);
      byp_data_reg <= din;
    end
  end

  assign dout  = empty ? '0 : (byp_sel_reg ? byp_data_reg : ram_q);
  assign level = count_reg;

endmodule

// File: rtl/sdram_wr_buffer.sv
// Camera-to-SDRAM write buffer: FIFOs pixels and issues fixed-length burst
// write requests at linear frame addresses. Option: FRAME_PINGPONG_EN.
module sdram_wr_buffer
  import sdram_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_AW     = 9,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = SDRAM_ADDR_W
) (
  input logic             sclk,
  input logic             rst_n,
  sdram_wr_buffer_if.master bus
);

  localparam int                BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [FIFO_AW:0]  BURST_THR  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

  wr_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] addr_cnt_reg, addr_cnt_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [ADDR_W-1:0] req_addr, addr_sum;
  logic [BEAT_W-1:0] beat_reg, beat_next;
  logic              pend_reg, pend_next;
  logic              overflow_reg;
  logic              apply_frame, burst_done, pop, wr_req;
  logic              full, empty;
  logic [FIFO_AW:0]  level;
  logic [DATA_W-1:0] head;

  // A frame restart only takes effect between bursts
  assign apply_frame = (state_reg == WR_IDLE) && (bus.frame_start || pend_reg);
  assign pop         = (state_reg == WR_BURST) && bus.wr_data_en && !empty;
  assign burst_done  = (state_reg == WR_BURST) && bus.wr_data_en &&
                       (beat_reg == BEAT_W'(BURST_LEN - 1));
  assign addr_sum    = addr_cnt_reg + BURST_STEP;

  sync_fifo_fwft #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .sclk  (sclk),
    .rst_n (rst_n),
    .flush (apply_frame),
    .push  (bus.pix_valid),
    .din   (bus.pix_data),
    .pop   (pop),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

`ifdef FRAME_PINGPONG_EN
  logic bank_sel_reg;
  logic frame_bank_reg;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_reg   <= 1'b0;
      frame_bank_reg <= 1'b0;
    end else if (apply_frame) begin
      frame_bank_reg <= bank_sel_reg;
      bank_sel_reg   <= ~bank_sel_reg;
    end
  end

  assign req_addr       = {bank_sel_reg, addr_cnt_reg[ADDR_W-2:0]};
  assign bus.frame_bank = frame_bank_reg;
`else
  assign req_addr = addr_cnt_reg;
`endif

  always_comb begin
    state_next    = state_reg;
    addr_cnt_next = addr_cnt_reg;
    wr_addr_next  = wr_addr_reg;
    beat_next     = beat_reg;
    pend_next     = pend_reg;
    wr_req        = 1'b0;
    unique case (state_reg)
      WR_IDLE: begin
        pend_next = 1'b0;
        if (apply_frame) begin
          addr_cnt_next = '0;
        end else if (level >= BURST_THR) begin
          state_next   = WR_REQ;
          wr_addr_next = req_addr;
        end
      end
      WR_REQ: begin
        wr_req = 1'b1;
        if (bus.frame_start) pend_next = 1'b1;
        if (bus.wr_ack) begin
          state_next = WR_BURST;
          beat_next  = '0;
        end
      end
      WR_BURST: begin
        if (bus.frame_start) pend_next = 1'b1;
        if (bus.wr_data_en)  beat_next = beat_reg + BEAT_W'(1);
        if (burst_done) begin
          state_next    = WR_IDLE;
          addr_cnt_next = (addr_sum == FRAME_END) ? '0 : addr_sum;
        end
      end
      default: state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WR_IDLE;
      addr_cnt_reg <= '0;
      wr_addr_reg  <= '0;
      beat_reg     <= '0;
      pend_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_cnt_reg <= addr_cnt_next;
      wr_addr_reg  <= wr_addr_next;
      beat_reg     <= beat_next;
      pend_reg     <= pend_next;
      overflow_reg <= overflow_reg | (bus.pix_valid & full & ~apply_frame);
    end
  end

  assign bus.wr_req     = wr_req;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = head;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_sdram_wr_buffer.sv
// Directed self-checking bench for sdram_wr_buffer (small frame size so a
// whole frame and its wrap fit in a short run).
module tb_sdram_wr_buffer;

  localparam int DW  = 16;
  localparam int AW  = 9;
  localparam int BL  = 8;
  localparam int FW  = 128;
  localparam int ADW = 24;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [DW-1:0] exp_q[$];
`ifdef FRAME_PINGPONG_EN
  logic bank_tb = 1'b0;
`endif

  always #5 sclk = ~sclk;

  sdram_wr_buffer_if #(.DATA_W(DW), .FIFO_AW(AW), .ADDR_W(ADW)) bus ();

  sdram_wr_buffer #(
    .DATA_W      (DW),
    .FIFO_AW     (AW),
    .BURST_LEN   (BL),
    .FRAME_WORDS (FW),
    .ADDR_W      (ADW)
  ) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADW-1:0] exp_addr(input int lin);
    logic [ADW-1:0] a;
    a = ADW'(lin);
`ifdef FRAME_PINGPONG_EN
    a[ADW-1] = bank_tb;
`endif
    return a;
  endfunction

  task automatic idle_inputs();
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.wr_ack      = 1'b0;
    bus.wr_data_en  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sclk);
    rst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
`ifdef FRAME_PINGPONG_EN
    bank_tb = 1'b0;
`endif
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b1;
      bus.pix_data    = base + DW'(i);
      exp_q.push_back(base + DW'(i));
    end
    @(negedge sclk);
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge sclk);
    bus.frame_start = 1'b1;
`ifdef FRAME_PINGPONG_EN
    bank_tb = ~bank_tb;
`endif
    @(negedge sclk);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_req(input string tag, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge sclk);
      if (bus.wr_req === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_req"}, 32'(seen), 32'd1);
  endtask

  // Ideal controller: ack the request, then pull BL words back to back.
  // Optionally pushes a pixel every beat, or pulses frame_start at one beat.
  task automatic serve_burst(input string tag, input logic [ADW-1:0] addr,
                             input bit push_too, input logic [DW-1:0] pbase,
                             input int fs_beat);
    bit seen;
    logic [DW-1:0] exp;
    wait_req(tag, seen);
    if (!seen) return;
    check_eq({tag, "_addr"}, 32'(bus.wr_addr), 32'(addr));
    bus.wr_ack = 1'b1;
    @(negedge sclk);
    bus.wr_ack = 1'b0;
    check_eq({tag, "_req_drop"}, 32'(bus.wr_req), 32'd0);
    for (int b = 0; b < BL; b++) begin
      bus.wr_data_en  = 1'b1;
      bus.frame_start = (b == fs_beat);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check_eq($sformatf("%s_d%0d", tag, b), 32'(bus.wr_data), 32'(exp));
      if (push_too) begin
        check_eq($sformatf("%s_lvl%0d", tag, b), 32'(bus.fifo_level), 32'd8);
        bus.pix_valid = 1'b1;
        bus.pix_data  = pbase + DW'(b);
        exp_q.push_back(pbase + DW'(b));
      end
      @(negedge sclk);
    end
    bus.wr_data_en  = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    $display("burst %s addr=0x%06h done", tag, addr);
  endtask

  initial begin
    idle_inputs();

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    check_eq("rst_wr_req",   32'(bus.wr_req),     32'd0);
    check_eq("rst_wr_addr",  32'(bus.wr_addr),    32'd0);
    check_eq("rst_wr_data",  32'(bus.wr_data),    32'd0);
    check_eq("rst_level",    32'(bus.fifo_level), 32'd0);
    check_eq("rst_overflow", 32'(bus.overflow),   32'd0);
`ifdef FRAME_PINGPONG_EN
    check_eq("rst_frame_bank", 32'(bus.frame_bank), 32'd0);
`endif
    rst_n = 1'b1;

    // First burst: words 1..8 at address 0
    push_words(8, 16'h0001);
    serve_burst("first", exp_addr(0), 1'b0, '0, -1);
    check_eq("first_level0", 32'(bus.fifo_level), 32'd0);
    check_eq("first_noreq",  32'(bus.wr_req),     32'd0);

    // Whole frame plus the first burst of the next: addresses wrap to 0
    do_reset();
    for (int k = 0; k <= FW / BL; k++) begin
      push_words(BL, 16'h1000 + 16'(k * BL));
      serve_burst($sformatf("frm%0d", k), exp_addr((k * BL) % FW), 1'b0, '0, -1);
    end

    // Overflow: 513 words without ack, the last one is dropped
    do_reset();
    push_words(513, 16'h2000);
    void'(exp_q.pop_back());
    check_eq("ovf_level",    32'(bus.fifo_level), 32'd512);
    check_eq("ovf_flag",     32'(bus.overflow),   32'd1);
    check_eq("ovf_req_held", 32'(bus.wr_req),     32'd1);
    for (int k = 0; k < 64; k++)
      serve_burst($sformatf("ovf%0d", k), exp_addr((k * BL) % FW), 1'b0, '0, -1);
    check_eq("ovf_drained",  32'(bus.fifo_level), 32'd0);
    check_eq("ovf_sticky",   32'(bus.overflow),   32'd1);

    // frame_start in the middle of the burst at 0x40
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push_words(BL, 16'h0100 + 16'(k * BL));
      serve_burst($sformatf("pre%0d", k), exp_addr(k * BL), 1'b0, '0, -1);
    end
    push_words(12, 16'h3000);
    serve_burst("fsmid", exp_addr(24'h40), 1'b0, '0, 3);
`ifdef FRAME_PINGPONG_EN
    bank_tb = ~bank_tb;
`endif
    exp_q.delete();
    repeat (2) @(negedge sclk);
    check_eq("fs_flushed", 32'(bus.fifo_level), 32'd0);
    check_eq("fs_noreq",   32'(bus.wr_req),     32'd0);
    push_words(BL, 16'h3100);
    serve_burst("fsnew", exp_addr(0), 1'b0, '0, -1);

    // frame_start together with a pixel: the pixel opens the new frame
    push_words(3, 16'h3200);
    @(negedge sclk);
    bus.frame_start = 1'b1;
    bus.pix_valid   = 1'b1;
    bus.pix_data    = 16'h3300;
`ifdef FRAME_PINGPONG_EN
    bank_tb = ~bank_tb;
`endif
    exp_q.delete();
    exp_q.push_back(16'h3300);
    push_words(7, 16'h3301);
    serve_burst("fspix", exp_addr(0), 1'b0, '0, -1);

    // Simultaneous push and pop at level 8 for 16 beats
    push_words(BL, 16'h4000);
    serve_burst("sim0", exp_addr(8), 1'b1, 16'h4100, -1);
    serve_burst("sim1", exp_addr(16), 1'b1, 16'h4200, -1);
    serve_burst("sim2", exp_addr(24), 1'b0, '0, -1);
    check_eq("sim_level0", 32'(bus.fifo_level), 32'd0);

`ifdef FRAME_PINGPONG_EN
    // Alternate bank halves per frame
    do_reset();
    pulse_frame();
    push_words(BL, 16'h5000);
    serve_burst("pp1", 24'h800000, 1'b0, '0, -1);
    check_eq("pp1_frame_bank", 32'(bus.frame_bank), 32'd0);
    pulse_frame();
    push_words(BL, 16'h5100);
    serve_burst("pp2", 24'h000000, 1'b0, '0, -1);
    check_eq("pp2_frame_bank", 32'(bus.frame_bank), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
